aes_enc_ctrl: RTL
=================

# aes_enc_ctrl

Sequencing controller for the iterative AES encryption datapath. It accepts one plaintext block through a valid/ready handshake and owns the state register and round counter. It drives the shared combinational `round` / `last_round` datapath and selects the round key from the expanded key schedule, one round per clock. It returns the ciphertext through a second valid/ready handshake. It sits between the block source and the shared round datapath plus `keyExpansion`, and replaces free-running, counter-without-reset sequencing.

## Interface
- `NK`, 4, key length in 32-bit words (4/6/8).
- `NR`, 10, number of rounds; must equal NK+6 (elaboration-time check, fatal otherwise).
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  plaintext offered.
- `in_ready`  out  1  controller can accept plaintext.
- `in_data`  in  128  plaintext block.
- `rk_idx`  out  $clog2(NR+1)  round-key index into expanded schedule.
- `rk_in`  in  128  round key `w[rk_idx*128 +: 128]`, combinational from schedule.
- `dp_state`  out  128  state presented to round datapath (= state register).
- `dp_round_out`  in  128  output of `round(dp_state, rk_in)`.
- `dp_last_out`  in  128  output of `last_round(dp_state, rk_in)`.
- `out_valid`  out  1  ciphertext available.
- `out_ready`  in  1  consumer takes ciphertext.
- `out_data`  out  128  ciphertext (= state register in DONE).
- `busy`  out  1  high in ROUND, FINAL, DONE.

## Operation
- FSM states: IDLE, ROUND, FINAL, DONE. Round counter `rnd` 0..NR.
- IDLE: `in_ready`=1, `rk_idx`=0. On `in_valid`: `state_q <= in_data ^ rk_in`, `rnd <= 1`, go ROUND.
- ROUND: `rk_idx`=`rnd`. `state_q <= dp_round_out`, `rnd <= rnd+1`. When `rnd==NR-1`, go FINAL.
- FINAL: `rk_idx`=NR. `state_q <= dp_last_out`, go DONE.
- DONE: `out_valid`=1, `out_data`=`state_q` stable. On `out_ready`, go IDLE and set `rnd <= 0`.
- `in_ready`=0 outside IDLE. `in_valid` while busy is ignored; the source must hold data.
- `state_q` changes only on the transitions above. `rk_in` must be stable from accept until DONE. Key changes are legal only in IDLE.
- Reset (including mid-operation): FSM to IDLE, `rnd`=0, `state_q`=0. The in-flight block is discarded and no output is produced.

## Timing
- Reset values: `in_ready`=1 (IDLE), `out_valid`=0, `busy`=0, `out_data`=0, `dp_state`=0, `rk_idx`=0.
- Accept at edge T0. `out_valid` rises after edge T0+NR, i.e. NR+1 cycles after accept (11/13/15 for NK=4/6/8).
- With `out_ready` held high, `out_valid` lasts 1 cycle. `in_ready` returns the cycle after the output handshake. Throughput is one block per NR+2 cycles.
- `out_ready` low: hold DONE indefinitely, with `out_data` unchanged.
- `rst` has priority over every handshake on the same edge.
- `in_ready`, `out_valid` and `busy` are decoded from FSM state only (registered, no combinational path from inputs).

## Configuration
- `AES_ENC_CTRL_PERF_EN` defined: adds output `blk_count` (32 bits). It increments on each output handshake, wraps at 2^32-1 → 0, and is cleared by `rst`.
- Undefined: no `blk_count` port and no counter logic. All other behaviour is identical.

## Structure
- Package `aes_pkg`: FSM state enum, `AES_BLK_W`=128, and the NK→NR function used by the elaboration check.
- One sub-module, `aes_round_cnt`: loadable, resettable round counter with `last` (rnd==NR-1) and `wrap` flags.
- The round/last_round datapath and `keyExpansion` stay outside this block. The bench wires them as in the encryptor.

## Test plan
- NK=4: key 000102…0f, pt 00112233445566778899aabbccddeeff → `out_data`=69c4e0d86a7b0430d8cdb78070b4c55a, `out_valid` exactly 11 cycles after accept.
- NK=8: key 000102…1f, same pt → 8ea2b7ca516745bfeafc49904b496089 after 15 cycles.
- Back-to-back with `out_ready`=1 and `in_valid`=1: blocks accepted every NR+2 cycles. `in_ready`=0 throughout ROUND/FINAL/DONE, and second-block data changed mid-flight does not corrupt the first result.
- Backpressure: `out_ready`=0 for 20 cycles in DONE → `out_valid` and `out_data` held constant. Release → one handshake, then IDLE.
- Reset asserted in ROUND at `rnd`=5 → next cycle IDLE, `out_valid`=0, `state_q`=0. A new block afterwards yields the correct ciphertext.
- With `AES_ENC_CTRL_PERF_EN`: after 3 blocks `blk_count`=3. `rst` → 0. Preload via force to FFFFFFFF, one block → 0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES encryption controller: block width,
// controller state encoding and the key-length to round-count rule.
package aes_pkg;

    localparam int AES_BLK_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } aes_state_e;

    // AES-128/192/256 use 10/12/14 rounds for 4/6/8-word keys.
    function automatic int aes_nr_for_nk(input int nk);
        return nk + 6;
    endfunction

endpackage

// File: rtl/aes_round_cnt.sv
// Loadable round counter for the AES controller; flags the last full round
// (NR-1) and the final round index (NR).
module aes_round_cnt
    import aes_pkg::*;
#(
    parameter int NR = 10,
    parameter int W  = $clog2(NR + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_inc,
    output logic [W-1:0] o_rnd,
    output logic         o_last,
    output logic         o_wrap
);

    logic [W-1:0] r_rnd;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rnd <= '0;
        end else if (i_load) begin
            r_rnd <= i_load_val;
        end else if (i_inc) begin
            r_rnd <= r_rnd + W'(1);
        end
    end

    assign o_rnd  = r_rnd;
    assign o_last = (r_rnd == W'(NR - 1));
    assign o_wrap = (r_rnd == W'(NR));

endmodule

// File: rtl/aes_enc_ctrl.sv
// Sequencing controller for the iterative AES encryptor: one round per clock.
// Define AES_ENC_CTRL_PERF_EN to add the blk_count output-handshake counter.
module aes_enc_ctrl
    import aes_pkg::*;
#(
    parameter  int NK  = 4,
    parameter  int NR  = 10,
    localparam int RKW = $clog2(NR + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] in_data,
    output logic [RKW-1:0]       rk_idx,
    input  logic [AES_BLK_W-1:0] rk_in,
    output logic [AES_BLK_W-1:0] dp_state,
    input  logic [AES_BLK_W-1:0] dp_round_out,
    input  logic [AES_BLK_W-1:0] dp_last_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] out_data,
    output logic                 busy
`ifdef AES_ENC_CTRL_PERF_EN
    ,
    output logic [31:0]          blk_count
`endif
);

    if (NR != aes_nr_for_nk(NK) || !(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_cfg
        $fatal(1, "aes_enc_ctrl: NK must be 4, 6 or 8 and NR must equal NK+6");
    end

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_ROUND = ST_ROUND;
    localparam logic [1:0] S_FINAL = ST_FINAL;
    localparam logic [1:0] S_DONE  = ST_DONE;

    logic [1:0]           r_fsm;
    logic [1:0]           w_fsm_d;
    logic [AES_BLK_W-1:0] r_state_q;
    logic [AES_BLK_W-1:0] w_state_d;
    logic                 w_cnt_load;
    logic [RKW-1:0]       w_cnt_load_val;
    logic                 w_cnt_inc;
    logic [RKW-1:0]       w_rnd;
    logic                 w_last;
    logic                 w_wrap;

    aes_round_cnt #(
        .NR (NR),
        .W  (RKW)
    ) u_round_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_inc      (w_cnt_inc),
        .o_rnd      (w_rnd),
        .o_last     (w_last),
        .o_wrap     (w_wrap)
    );

    // NOTE: every signal assigned here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        w_fsm_d        = r_fsm;
        w_state_d      = r_state_q;
        w_cnt_load     = 1'b0;
        w_cnt_load_val = '0;
        w_cnt_inc      = 1'b0;
        case (r_fsm)
            S_IDLE: begin
                if (in_valid) begin
                    w_fsm_d        = S_ROUND;
                    w_state_d      = in_data ^ rk_in;
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = RKW'(1);
                end
            end
            S_ROUND: begin
                w_state_d = dp_round_out;
                w_cnt_inc = !w_wrap;
                if (w_last) begin
                    w_fsm_d = S_FINAL;
                end
            end
            S_FINAL: begin
                w_state_d = dp_last_out;
                w_fsm_d   = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    w_fsm_d    = S_IDLE;
                    w_cnt_load = 1'b1;
                end
            end
            default: w_fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm     <= S_IDLE;
            r_state_q <= '0;
        end else begin
            r_fsm     <= w_fsm_d;
            r_state_q <= w_state_d;
        end
    end

    // Handshake flags decode only the registered state, never the inputs.
    assign in_ready  = (r_fsm == S_IDLE);
    assign out_valid = (r_fsm == S_DONE);
    assign busy      = (r_fsm != S_IDLE);
    assign dp_state  = r_state_q;
    assign out_data  = r_state_q;
    assign rk_idx    = in_ready ? '0 : w_rnd;

`ifdef AES_ENC_CTRL_PERF_EN
    logic [31:0] r_blk_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blk_count <= '0;
        end else if (out_valid && out_ready) begin
            r_blk_count <= r_blk_count + 32'd1;
        end
    end

    assign blk_count = r_blk_count;
`endif

endmodule
